// File: rtl/eeg_sample_conditioner.sv
// EEG front-end conditioner: 4-sample moving average scaled to 8 bits, with
// jump-based artifact detection and a fixed-length blanking period.
module eeg_sample_conditioner #(
  parameter logic [9:0] JUMP_THR  = 10'd200,
  parameter int         BLANK_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_sample,
  input  logic       raw_valid,
  output logic [7:0] eeg_signal,
  output logic       eeg_valid,
  output logic       artifact
);

  localparam int BW = $clog2(BLANK_LEN + 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_BLANK} state_t;

  state_t          r_state, w_state_next;
  logic [9:0]      r_window [0:3];
  logic [9:0]      w_shift_in [0:3];
  logic [1:0]      r_fill_cnt, w_fill_cnt_next;
  logic [BW-1:0]   r_blank_cnt, w_blank_cnt_next;
  logic [9:0]      r_last;
  logic [7:0]      r_eeg_signal, w_eeg_signal_next;
  logic            r_eeg_valid, w_eeg_valid_next;
  logic            r_artifact, w_artifact_next;
  logic            w_shift, w_clear, w_load_last;
  logic [11:0]     w_sum;
  logic [9:0]      w_diff;
  logic            w_jump;

  // Sum of the window as it will be after the incoming sample is shifted in.
  assign w_sum  = {2'b00, raw_sample} + {2'b00, r_window[0]}
                + {2'b00, r_window[1]} + {2'b00, r_window[2]};
  assign w_diff = (raw_sample >= r_last) ? (raw_sample - r_last) : (r_last - raw_sample);
  assign w_jump = (w_diff > JUMP_THR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    w_fill_cnt_next   = r_fill_cnt;
    w_blank_cnt_next  = r_blank_cnt;
    w_shift           = 1'b0;
    w_clear           = 1'b0;
    w_load_last       = 1'b0;
    w_eeg_valid_next  = 1'b0;
    w_eeg_signal_next = r_eeg_signal;
    w_artifact_next   = r_artifact;
    if (raw_valid) begin
      case (r_state)
        S_FILL: begin
          w_shift     = 1'b1;
          w_load_last = 1'b1;
          if (r_fill_cnt == 2'd3) begin
            w_fill_cnt_next   = 2'd0;
            w_eeg_valid_next  = 1'b1;
            w_eeg_signal_next = 8'(w_sum >> 4);
            w_state_next      = S_RUN;
          end else begin
            w_fill_cnt_next = r_fill_cnt + 2'd1;
          end
        end
        S_RUN: begin
          w_eeg_valid_next = 1'b1;
          if (w_jump) begin
            // The offending sample is discarded sample number one.
            if (BLANK_LEN <= 1) begin
              w_clear          = 1'b1;
              w_fill_cnt_next  = 2'd0;
              w_blank_cnt_next = '0;
              w_state_next     = S_FILL;
            end else begin
              w_artifact_next  = 1'b1;
              w_blank_cnt_next = BW'(1);
              w_state_next     = S_BLANK;
            end
          end else begin
            w_shift           = 1'b1;
            w_load_last       = 1'b1;
            w_eeg_signal_next = 8'(w_sum >> 4);
          end
        end
        S_BLANK: begin
          w_eeg_valid_next = 1'b1;
          if (r_blank_cnt == BW'(BLANK_LEN - 1)) begin
            w_clear          = 1'b1;
            w_fill_cnt_next  = 2'd0;
            w_blank_cnt_next = '0;
            w_artifact_next  = 1'b0;
            w_state_next     = S_FILL;
          end else begin
            w_blank_cnt_next = r_blank_cnt + BW'(1);
          end
        end
        default: w_state_next = S_FILL;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_window
      if (gi == 0) begin : g_head
        assign w_shift_in[gi] = raw_sample;
      end else begin : g_tail
        assign w_shift_in[gi] = r_window[gi-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_window[gi] <= 10'd0;
        else if (w_clear) r_window[gi] <= 10'd0;
        else if (w_shift) r_window[gi] <= w_shift_in[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fill_cnt   <= 2'd0;
      r_blank_cnt  <= '0;
      r_last       <= 10'd0;
      r_eeg_signal <= 8'd0;
      r_eeg_valid  <= 1'b0;
      r_artifact   <= 1'b0;
    end else begin
      r_fill_cnt   <= w_fill_cnt_next;
      r_blank_cnt  <= w_blank_cnt_next;
      r_eeg_signal <= w_eeg_signal_next;
      r_eeg_valid  <= w_eeg_valid_next;
      r_artifact   <= w_artifact_next;
      if (w_load_last) r_last <= raw_sample;
    end
  end

  assign eeg_signal = r_eeg_signal;
  assign eeg_valid  = r_eeg_valid;
  assign artifact   = r_artifact;

endmodule

// File: doc/eeg_sample_conditioner.md
EEG_SAMPLE_CONDITIONER -- requirements
Module: eeg_sample_conditioner

Interface
REQ-001 Parameter: JUMP_THR, default 10'd200, largest sample-to-sample step (raw LSBs) not treated as an artifact.
REQ-002 Parameter: BLANK_LEN, default 16, number of raw samples discarded after an artifact.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 raw_sample  input  10  unsigned ADC sample, sampled only when raw_valid=1.
REQ-007 raw_valid  input  1  single-cycle strobe marking raw_sample valid.
REQ-008 eeg_signal  output  8  conditioned sample for the downstream P300 detector's eeg_signal input.
REQ-009 eeg_valid  output  1  one-cycle pulse marking an eeg_signal update.
REQ-010 artifact  output  1  high while the block is blanking after a detected artifact.

Function
REQ-011 The block SHALL implement states FILL, RUN, BLANK; all outputs registered.
REQ-012 FILL: each accepted sample is shifted into a 4-deep window; fill counter 0..3; no eeg_valid for the first three samples; the fourth sample produces an output and moves to RUN.
REQ-013 RUN: each accepted sample is jump-checked against the last accepted sample; if |raw_sample - last| > JUMP_THR go to BLANK, otherwise shift into the window and produce an output.
REQ-014 Jump equal to JUMP_THR SHALL NOT be an artifact (strictly greater only).
REQ-015 Output arithmetic: 12-bit sum of the 4 window entries (after shift); eeg_signal = sum[11:4] (divide by 16, i.e. average scaled 10->8 bits); no overflow or saturation possible.
REQ-016 Latency: eeg_signal and eeg_valid update on the clock edge that accepts the sample (visible the cycle after raw_valid is sampled high).
REQ-017 Entering BLANK: artifact=1 on the same edge; the offending sample is not shifted in, last-sample register not updated; eeg_signal holds its previous value; eeg_valid pulses with the held value.
REQ-018 BLANK: each raw_valid strobe increments a blank counter, is discarded, and pulses eeg_valid with the held eeg_signal; no jump check.
REQ-019 On the BLANK_LEN-th discarded sample: clear window and fill counter, artifact=0, go to FILL; the triggering sample counts as discarded sample 1.
REQ-020 FILL performs no jump check; the first sample after FILL entry SHALL load the last-sample register unconditionally.
REQ-021 raw_valid=0: no state, window, counter or eeg_signal change; eeg_valid=0.
REQ-022 Back-to-back raw_valid on consecutive cycles SHALL be accepted every cycle without loss.

Reset
REQ-023 Reset SHALL asynchronously force: state FILL, window entries 0, fill/blank counters 0, last-sample 0, eeg_signal=8'd0, eeg_valid=0, artifact=0.
REQ-024 Reset asserted mid-operation (any state, including BLANK) SHALL take effect immediately with no eeg_valid pulse until four new samples are accepted after release.
REQ-025 A raw_valid coinciding with reset asserted SHALL be ignored.

Verification
REQ-026 Reset, then four samples of 200 -> no eeg_valid for samples 1-3; eeg_valid pulse with eeg_signal=50 after sample 4.
REQ-027 Steady at 200, then 220,240,260,280 -> eeg_signal 51, 53, 57, 62 with one eeg_valid pulse each.
REQ-028 Steady at 200, then 500 -> artifact=1, eeg_signal held 50 with eeg_valid; after 16 discarded samples artifact=0; the next 3 samples produce no eeg_valid, the 4th does.
REQ-029 Steady at 200, then 400 (jump exactly 200) -> artifact stays 0, eeg_signal=62.
REQ-030 Four samples of 1023 -> eeg_signal=255; reset pulse mid-BLANK -> eeg_signal=0, artifact=0, eeg_valid=0 immediately, FILL behaviour afterwards.
